mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single write port and single read port of the 8x16 register-file memory between NREQ requesters. Each port uses an independent round-robin arbiter. The write port adds a lock, so one requester can hold it for a burst. Read grants are combinational; read data returns registered one cycle later, tagged with the requester index. Sits between the client blocks and the memory instance.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 3, memory address width
DW, 16, memory data width

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
wr_req  in  NREQ  per-requester write request
wr_lock  in  NREQ  per-requester lock, meaningful only with wr_req
wr_addr  in  NREQ*AW  flattened write addresses, requester i at [i*AW +: AW]
wr_data  in  NREQ*DW  flattened write data, requester i at [i*DW +: DW]
wr_gnt  out  NREQ  one-hot write grant, combinational
rd_req  in  NREQ  per-requester read request
rd_addr  in  NREQ*AW  flattened read addresses
rd_gnt  out  NREQ  one-hot read grant, combinational
rd_valid  out  1  read response valid, one cycle after grant
rd_id  out  $clog2(NREQ)  index of the responding requester
rd_data  out  DW  registered read data
m_w_en  out  1  to memory write enable
m_w_addr  out  AW  to memory write address
m_w_data  out  DW  to memory write data
m_r_addr  out  AW  to memory read address
m_r_data  in  DW  from memory, combinational read of m_r_addr

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, state=ARB, owner=0, rd_valid=0, rd_id=0, rd_data=0. While rst_n=0, wr_gnt=0, rd_gnt=0 and m_w_en=0.
- Round-robin: grant the first asserted request at or after ptr, wrapping from NREQ-1 to 0. No request: grant=0 and ptr holds. After a grant to i, ptr <= (i+1) mod NREQ.
- Write FSM, states ARB and LOCKED:
  - ARB: normal round-robin. A grant to i with wr_lock[i]=1 moves to LOCKED with owner=i.
  - LOCKED: wr_gnt[owner]=wr_req[owner]; all other write requests are blocked. The FSM returns to ARB in any cycle where wr_req[owner]=0 or wr_lock[owner]=0. In that same cycle wr_ptr <= owner+1.
  - A cycle with wr_req[owner]=1 and wr_lock[owner]=0 still grants owner.
- Write muxing: m_w_en = |wr_gnt. m_w_addr and m_w_data come from the granted requester and are 0 when there is no grant. The write commits at the same clock edge as the grant, so write latency is 0 cycles.
- Read: round-robin with no lock. m_r_addr comes from the granted requester, 0 when idle. On the edge after a grant: rd_valid=1, rd_id=i, rd_data=m_r_data. With no grant, rd_valid=0 and rd_id/rd_data hold their values.
- Read and write to the same address in the same cycle: rd_data returns the OLD memory contents, unless the optional feature is enabled.
- A requester may drop its request before it is granted; no grant is then recorded for it.
- The read and write ports are fully independent; one requester may hold both grants in the same cycle.
- Reset during LOCKED aborts the lock. A read response in flight is discarded (rd_valid=0).

Optional Feature:
MEM_ARB_BYPASS_EN
- Defined: if m_w_en=1 and m_w_addr==m_r_addr while a read grant is active, rd_data captures m_w_data (write-first).
- Undefined: rd_data always captures m_r_data (read-first).

Decomposition:
- Package mem_arb_pkg holds:
  - wr_state_t enum {ARB, LOCKED}
  - default AW=3 and DW=16 constants
  - localparam function for the index width
- Sub-module rr_arbiter (req, ptr -> one-hot gnt, gnt_idx) is purely combinational and instantiated twice, once per port.

Test Plan:
- Reset: rst_n=0 mid-traffic -> rd_valid=0, all grants 0 and m_w_en=0 immediately, without waiting for a clk edge.
- Write fairness: wr_req=4'b1111 held for 8 cycles, no lock -> wr_gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
- Lock: requester 2 holds wr_lock=1 with wr_req=1 for 3 cycles while the others request -> wr_gnt=0100 for 3 cycles. Requester 2 drops the lock -> next grant 1000, then 0001.
- Read latency: requester 1 reads addr 5 holding 16'hBEEF -> rd_gnt=0010 that cycle; next cycle rd_valid=1, rd_id=1, rd_data=16'hBEEF.
- Same-cycle hazard: write 16'h1234 to addr 3 (old value 16'h0000) and read addr 3 in the same cycle -> rd_data=16'h0000 without MEM_ARB_BYPASS_EN, 16'h1234 with it.
- Idle: all requests 0 -> m_w_en=0, m_w_addr=0, m_r_addr=0, pointers unchanged, rd_valid=0 on the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter slice.
package mem_arb_pkg;

  localparam int ARB_AW = 3;
  localparam int ARB_DW = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } wr_state_t;

  // Requester index width; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Client/memory bundle for mem_port_arbiter; slave = arbiter side, master = clients + memory.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = ARB_AW,
  parameter int DW   = ARB_DW
) ();

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0]    wr_req;
  logic [NREQ-1:0]    wr_lock;
  logic [NREQ*AW-1:0] wr_addr;
  logic [NREQ*DW-1:0] wr_data;
  logic [NREQ-1:0]    wr_gnt;

  logic [NREQ-1:0]    rd_req;
  logic [NREQ*AW-1:0] rd_addr;
  logic [NREQ-1:0]    rd_gnt;
  logic               rd_valid;
  logic [IW-1:0]      rd_id;
  logic [DW-1:0]      rd_data;

  logic               m_w_en;
  logic [AW-1:0]      m_w_addr;
  logic [DW-1:0]      m_w_data;
  logic [AW-1:0]      m_r_addr;
  logic [DW-1:0]      m_r_data;

  modport slave (
    input  wr_req, wr_lock, wr_addr, wr_data, rd_req, rd_addr, m_r_data,
    output wr_gnt, rd_gnt, rd_valid, rd_id, rd_data,
    output m_w_en, m_w_addr, m_w_data, m_r_addr
  );

  modport master (
    output wr_req, wr_lock, wr_addr, wr_data, rd_req, rd_addr, m_r_data,
    input  wr_gnt, rd_gnt, rd_valid, rd_id, rd_data,
    input  m_w_en, m_w_addr, m_w_data, m_r_addr
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  int            j;
  logic [IW-1:0] jj;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NREQ; k++) begin
      j  = (int'(ptr) + k) % NREQ;
      jj = j[IW-1:0];
      if (!found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        gnt_idx = jj;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin write/read port sharing for the 8x16 register file, with write burst lock.
// Build option MEM_ARB_BYPASS_EN: same-address read during a write returns the new data.
//   state  | meaning
//   ARB    | round-robin write arbitration
//   LOCKED | write port held by owner until it drops wr_req or wr_lock
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = ARB_AW,
  parameter int DW   = ARB_DW
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int            IW   = idx_w(NREQ);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  wr_state_t     wr_state_q, wr_state_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic [IW-1:0] rd_id_q, rd_id_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic [NREQ-1:0] wr_arb_gnt, rd_arb_gnt;
  logic [IW-1:0]   wr_arb_idx, rd_arb_idx;
  logic [NREQ-1:0] wr_gnt_c, wr_gnt, rd_gnt;
  logic            m_w_en;
  logic [AW-1:0]   m_w_addr, m_r_addr;
  logic [DW-1:0]   m_w_data, rd_capture;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_wr_rr (
    .req     (bus.wr_req),
    .ptr     (wr_ptr_q),
    .gnt     (wr_arb_gnt),
    .gnt_idx (wr_arb_idx)
  );

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rd_rr (
    .req     (bus.rd_req),
    .ptr     (rd_ptr_q),
    .gnt     (rd_arb_gnt),
    .gnt_idx (rd_arb_idx)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    wr_ptr_d   = wr_ptr_q;
    owner_d    = owner_q;
    wr_gnt_c   = '0;
    case (wr_state_q)
      ARB: begin
        wr_gnt_c = wr_arb_gnt;
        if (|wr_arb_gnt) begin
          wr_ptr_d = wrap_inc(wr_arb_idx);
          if (bus.wr_lock[wr_arb_idx]) begin
            wr_state_d = LOCKED;
            owner_d    = wr_arb_idx;
          end
        end
      end
      LOCKED: begin
        // A final cycle with req but no lock is still granted to the owner.
        wr_gnt_c[owner_q] = bus.wr_req[owner_q];
        if (!bus.wr_req[owner_q] || !bus.wr_lock[owner_q]) begin
          wr_state_d = ARB;
          wr_ptr_d   = wrap_inc(owner_q);
        end
      end
      default: wr_state_d = ARB;
    endcase
  end

  // Grants are combinational, so they must be forced low while reset is held.
  assign wr_gnt = rst_n ? wr_gnt_c   : '0;
  assign rd_gnt = rst_n ? rd_arb_gnt : '0;
  assign m_w_en = |wr_gnt;

  always_comb begin
    m_w_addr = '0;
    m_w_data = '0;
    m_r_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (wr_gnt[i]) begin
        m_w_addr = bus.wr_addr[i*AW +: AW];
        m_w_data = bus.wr_data[i*DW +: DW];
      end
      if (rd_gnt[i]) begin
        m_r_addr = bus.rd_addr[i*AW +: AW];
      end
    end
  end

`ifdef MEM_ARB_BYPASS_EN
  assign rd_capture = (m_w_en && (m_w_addr == m_r_addr)) ? m_w_data : bus.m_r_data;
`else
  assign rd_capture = bus.m_r_data;
`endif

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = |rd_gnt;
    rd_id_d    = rd_id_q;
    rd_data_d  = rd_data_q;
    if (|rd_gnt) begin
      rd_ptr_d  = wrap_inc(rd_arb_idx);
      rd_id_d   = rd_arb_idx;
      rd_data_d = rd_capture;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= ARB;
      wr_ptr_q   <= '0;
      owner_q    <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_ptr_q   <= wr_ptr_d;
      owner_q    <= owner_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.wr_gnt   = wr_gnt;
  assign bus.rd_gnt   = rd_gnt;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_id    = rd_id_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.m_w_en   = m_w_en;
  assign bus.m_w_addr = m_w_addr;
  assign bus.m_w_data = m_w_data;
  assign bus.m_r_addr = m_r_addr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with an 8x16 memory and a rule-level reference model.
module tb_mem_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus_if ();

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Memory instance stand-in: combinational read, write on posedge.
  logic [DW-1:0] mem [8] = '{default: '0};
  assign bus_if.m_r_data = mem[bus_if.m_r_addr];
  always @(posedge clk) if (bus_if.m_w_en) mem[bus_if.m_w_addr] <= bus_if.m_w_data;

  // Reference model state
  int            m_wptr, m_rptr, m_owner;
  bit            m_locked;
  logic [DW-1:0] m_mem [8];
  bit            e_rvalid;
  int            e_rid;
  logic [DW-1:0] e_rdata;
  int            e_widx, e_ridx;
  logic [NREQ-1:0] e_wgnt, e_rgnt;
  logic          e_wen;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_wdata;

  function automatic int rr_pick(input logic [NREQ-1:0] req, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_wptr = 0; m_rptr = 0; m_owner = 0; m_locked = 0;
    e_rvalid = 0; e_rid = 0; e_rdata = '0;
  endtask

  task automatic model_comb();
    if (m_locked) e_widx = bus_if.wr_req[m_owner] ? m_owner : -1;
    else          e_widx = rr_pick(bus_if.wr_req, m_wptr);
    e_ridx = rr_pick(bus_if.rd_req, m_rptr);
    e_wgnt = '0; e_rgnt = '0; e_wen = 0; e_waddr = '0; e_wdata = '0; e_raddr = '0;
    if (e_widx >= 0) begin
      e_wgnt[e_widx] = 1'b1;
      e_wen   = 1'b1;
      e_waddr = bus_if.wr_addr[e_widx*AW +: AW];
      e_wdata = bus_if.wr_data[e_widx*DW +: DW];
    end
    if (e_ridx >= 0) begin
      e_rgnt[e_ridx] = 1'b1;
      e_raddr = bus_if.rd_addr[e_ridx*AW +: AW];
    end
  endtask

  task automatic model_clock();
    logic [DW-1:0] cap;
    if (e_ridx >= 0) begin
      cap = m_mem[e_raddr];
`ifdef MEM_ARB_BYPASS_EN
      if (e_wen && e_waddr == e_raddr) cap = e_wdata;
`endif
      e_rvalid = 1; e_rid = e_ridx; e_rdata = cap;
      m_rptr = (e_ridx + 1) % NREQ;
    end else begin
      e_rvalid = 0;
    end
    if (m_locked) begin
      if (!bus_if.wr_req[m_owner] || !bus_if.wr_lock[m_owner]) begin
        m_locked = 0;
        m_wptr   = (m_owner + 1) % NREQ;
      end
    end else if (e_widx >= 0) begin
      m_wptr = (e_widx + 1) % NREQ;
      if (bus_if.wr_lock[e_widx]) begin
        m_locked = 1;
        m_owner  = e_widx;
      end
    end
    if (e_wen) m_mem[e_waddr] = e_wdata;
  endtask

  task automatic drive(input logic [NREQ-1:0] wreq, input logic [NREQ-1:0] wlock,
                       input logic [NREQ-1:0] rreq);
    bus_if.wr_req  = wreq;
    bus_if.wr_lock = wlock;
    bus_if.rd_req  = rreq;
  endtask

  task automatic randomize_payload();
    bus_if.wr_addr = 12'($urandom());
    bus_if.rd_addr = 12'($urandom());
    bus_if.wr_data = {$urandom(), $urandom()};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b1111, 4'b0000, 4'b1111);
    randomize_payload();
    model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    #2;
    checks++; if (bus_if.wr_gnt !== 4'b0000) begin errors++; $display("FAIL rst_wr_gnt got=%b exp=0000", bus_if.wr_gnt); end
    checks++; if (bus_if.rd_gnt !== 4'b0000) begin errors++; $display("FAIL rst_rd_gnt got=%b exp=0000", bus_if.rd_gnt); end
    checks++; if (bus_if.m_w_en !== 1'b0) begin errors++; $display("FAIL rst_m_w_en got=%b exp=0", bus_if.m_w_en); end
    @(posedge clk); #1;
    checks++; if (bus_if.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%b exp=0", bus_if.rd_valid); end
    checks++; if (bus_if.rd_id !== 2'd0) begin errors++; $display("FAIL rst_rd_id got=%0d exp=0", bus_if.rd_id); end
    checks++; if (bus_if.rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data got=%h exp=0000", bus_if.rd_data); end
    @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
  endtask

  task automatic test_write_fairness();
    logic [NREQ-1:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(4'b1111, 4'b0000, 4'b0000);
      randomize_payload();
      #1; model_comb();
      checks++; if (bus_if.wr_gnt !== seq[c]) begin errors++; $display("FAIL fair_wr_gnt cyc=%0d got=%b exp=%b", c, bus_if.wr_gnt, seq[c]); end
      checks++; if (bus_if.m_w_addr !== e_waddr || bus_if.m_w_data !== e_wdata) begin errors++; $display("FAIL fair_w_payload cyc=%0d got=%0d/%h exp=%0d/%h", c, bus_if.m_w_addr, bus_if.m_w_data, e_waddr, e_wdata); end
      model_clock();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock();
    logic [NREQ-1:0] wreq [6] = '{4'b0100, 4'b1111, 4'b1111, 4'b1011, 4'b1011, 4'b1011};
    logic [NREQ-1:0] wlck [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic [NREQ-1:0] seq  [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0001};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(wreq[c], wlck[c], 4'b0000);
      randomize_payload();
      #1; model_comb();
      checks++; if (bus_if.wr_gnt !== seq[c]) begin errors++; $display("FAIL lock_wr_gnt cyc=%0d got=%b exp=%b", c, bus_if.wr_gnt, seq[c]); end
      model_clock();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_read_latency();
    @(negedge clk);
    drive(4'b0001, 4'b0000, 4'b0000);
    bus_if.wr_addr[0 +: AW] = 3'd5;
    bus_if.wr_data[0 +: DW] = 16'hBEEF;
    #1; model_comb(); model_clock();
    @(posedge clk); #1;
    @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0010);
    bus_if.rd_addr[1*AW +: AW] = 3'd5;
    #1; model_comb();
    checks++; if (bus_if.rd_gnt !== 4'b0010) begin errors++; $display("FAIL lat_rd_gnt got=%b exp=0010", bus_if.rd_gnt); end
    checks++; if (bus_if.m_r_addr !== 3'd5) begin errors++; $display("FAIL lat_m_r_addr got=%0d exp=5", bus_if.m_r_addr); end
    model_clock();
    @(posedge clk); #1;
    checks++; if (bus_if.rd_valid !== 1'b1 || bus_if.rd_id !== 2'd1) begin errors++; $display("FAIL lat_rd_valid_id got=%b/%0d exp=1/1", bus_if.rd_valid, bus_if.rd_id); end
    checks++; if (bus_if.rd_data !== 16'hBEEF) begin errors++; $display("FAIL lat_rd_data got=%h exp=beef", bus_if.rd_data); end
  endtask

  task automatic test_same_cycle_hazard();
    logic [DW-1:0] exp_rd;
`ifdef MEM_ARB_BYPASS_EN
    exp_rd = 16'h1234;
`else
    exp_rd = 16'h0000;
`endif
    @(negedge clk);
    drive(4'b0001, 4'b0000, 4'b0000);
    bus_if.wr_addr[0 +: AW] = 3'd3;
    bus_if.wr_data[0 +: DW] = 16'h0000;
    #1; model_comb(); model_clock();
    @(posedge clk); #1;
    @(negedge clk);
    drive(4'b0001, 4'b0000, 4'b0100);
    bus_if.wr_data[0 +: DW] = 16'h1234;
    bus_if.rd_addr[2*AW +: AW] = 3'd3;
    #1; model_comb(); model_clock();
    @(posedge clk); #1;
    checks++; if (bus_if.rd_data !== exp_rd || bus_if.rd_id !== 2'd2) begin errors++; $display("FAIL hazard_rd_data got=%h id=%0d exp=%h id=2", bus_if.rd_data, bus_if.rd_id, exp_rd); end
    @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0100);
    #1; model_comb(); model_clock();
    @(posedge clk); #1;
    checks++; if (bus_if.rd_data !== 16'h1234) begin errors++; $display("FAIL hazard_after_write got=%h exp=1234", bus_if.rd_data); end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(4'b0000, 4'b0000, 4'b0000);
      randomize_payload();
      #1; model_comb();
      checks++; if (bus_if.m_w_en !== 1'b0 || bus_if.m_w_addr !== 3'd0 || bus_if.m_r_addr !== 3'd0) begin errors++; $display("FAIL idle_outputs got=%b/%0d/%0d exp=0/0/0", bus_if.m_w_en, bus_if.m_w_addr, bus_if.m_r_addr); end
      model_clock();
      @(posedge clk); #1;
      checks++; if (bus_if.rd_valid !== 1'b0) begin errors++; $display("FAIL idle_rd_valid got=%b exp=0", bus_if.rd_valid); end
    end
    // Pointers must have held across the idle cycles.
    @(negedge clk);
    drive(4'b1111, 4'b0000, 4'b1111);
    #1; model_comb();
    checks++; if (bus_if.wr_gnt !== e_wgnt || bus_if.rd_gnt !== e_rgnt) begin errors++; $display("FAIL idle_ptr_hold got=%b/%b exp=%b/%b", bus_if.wr_gnt, bus_if.rd_gnt, e_wgnt, e_rgnt); end
    model_clock();
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      drive(4'($urandom()), 4'($urandom()) & 4'($urandom()), 4'($urandom()));
      randomize_payload();
      #1; model_comb();
      checks++; if (bus_if.wr_gnt !== e_wgnt) begin errors++; $display("FAIL rnd_wr_gnt cyc=%0d got=%b exp=%b", c, bus_if.wr_gnt, e_wgnt); end
      checks++; if (bus_if.rd_gnt !== e_rgnt) begin errors++; $display("FAIL rnd_rd_gnt cyc=%0d got=%b exp=%b", c, bus_if.rd_gnt, e_rgnt); end
      checks++; if (bus_if.m_w_en !== e_wen || bus_if.m_w_addr !== e_waddr || bus_if.m_w_data !== e_wdata) begin errors++; $display("FAIL rnd_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus_if.m_w_en, bus_if.m_w_addr, bus_if.m_w_data, e_wen, e_waddr, e_wdata); end
      checks++; if (bus_if.m_r_addr !== e_raddr) begin errors++; $display("FAIL rnd_m_r_addr cyc=%0d got=%0d exp=%0d", c, bus_if.m_r_addr, e_raddr); end
      model_clock();
      @(posedge clk); #1;
      checks++; if (bus_if.rd_valid !== e_rvalid || bus_if.rd_id !== 2'(e_rid) || bus_if.rd_data !== e_rdata) begin errors++; $display("FAIL rnd_read_resp cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus_if.rd_valid, bus_if.rd_id, bus_if.rd_data, e_rvalid, e_rid, e_rdata); end
    end
  endtask

  task automatic test_reset_mid_traffic();
    // Requester 1 takes the lock and a read is left in flight when reset hits.
    @(negedge clk);
    drive(4'b0010, 4'b0010, 4'b1111);
    randomize_payload();
    #1; model_comb(); model_clock();
    @(posedge clk); #1;
    checks++; if (bus_if.rd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_rd_valid got=%b exp=1", bus_if.rd_valid); end
    drive(4'b1111, 4'b1111, 4'b1111);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus_if.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got=%b exp=0", bus_if.rd_valid); end
    checks++; if (bus_if.wr_gnt !== 4'b0000 || bus_if.rd_gnt !== 4'b0000 || bus_if.m_w_en !== 1'b0) begin errors++; $display("FAIL mid_grants got=%b/%b/%b exp=0000/0000/0", bus_if.wr_gnt, bus_if.rd_gnt, bus_if.m_w_en); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'b0000, 4'b1111);
    #1; model_comb();
    checks++; if (bus_if.wr_gnt !== 4'b0001 || bus_if.rd_gnt !== 4'b0001) begin errors++; $display("FAIL mid_post_gnt got=%b/%b exp=0001/0001", bus_if.wr_gnt, bus_if.rd_gnt); end
    model_clock();
    @(posedge clk); #1;
    test_random(40);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_fairness();
    test_lock();
    test_read_latency();
    test_same_cycle_hazard();
    test_idle();
    test_random(300);
    test_reset_mid_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
